// File: rtl/module_fsm_seq.sv
// module_fsm_seq: press-driven operand-entry sequencer. It steps through N_OPS
// operand captures, launches the arithmetic unit, waits for completion with an
// optional timeout, shows the result, then issues a timed datapath clear.
module module_fsm_seq #(
    parameter int unsigned N_OPS       = 2,
    parameter int unsigned SEL_W       = ($clog2(N_OPS) > 1) ? $clog2(N_OPS) : 1,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CLR_CYC     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             press,
    input  logic             cancel,
    input  logic             op_done,
    output logic [SEL_W-1:0] y_sel,
    output logic             load_en,
    output logic             start,
    output logic             y_disp,
    output logic             reset_2,
    output logic             busy,
    output logic             err
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int unsigned TMO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int unsigned CLR_LAST_I = (CLR_CYC > 0) ? CLR_CYC - 1 : 0;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OPS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_LAST_I);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_LAST_I);
    localparam logic             TMO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTER = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SHOW  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic               r_press_q;
    logic [TMR_W-1:0]   r_tmr;
    logic [CLR_W-1:0]   r_clr;
    logic [SEL_W-1:0]   r_y_sel;
    logic               r_load_en;
    logic               r_start;
    logic               r_y_disp;
    logic               r_reset_2;
    logic               r_busy;
    logic               r_err;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [CLR_W-1:0]   w_clr_nxt;
    logic [SEL_W-1:0]   w_y_sel_nxt;
    logic               w_load_nxt;
    logic               w_err_nxt;
    logic               w_go_clear;
    logic               w_pe;

    // Rising edge of the debounced press level: a held press is one event.
    assign w_pe = press & ~r_press_q;

    // Next-state, counter and registered-output values.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_nxt   = r_tmr;
        w_clr_nxt   = r_clr;
        w_err_nxt   = r_err;
        w_load_nxt  = 1'b0;
        w_go_clear  = 1'b0;
        w_y_sel_nxt = r_idx;

        case (r_state)
            S_IDLE: begin
                if (w_pe) begin
                    w_state_nxt = S_ENTER;
                    w_idx_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_ENTER: begin
                if (cancel) begin
                    w_go_clear = 1'b1;
                end else if (w_pe) begin
                    w_load_nxt = 1'b1;
                    if (r_idx < LAST_IDX) begin
                        w_idx_nxt = r_idx + SEL_W'(1);
                    end else begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                if (cancel) begin
                    w_go_clear = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_tmr_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (cancel) begin
                    w_go_clear = 1'b1;
                end else if (op_done) begin
                    w_state_nxt = S_SHOW;
                end else if (TMO_EN && (r_tmr == TMR_LAST)) begin
                    w_err_nxt  = 1'b1;
                    w_go_clear = 1'b1;
                end else if (TMO_EN) begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            S_SHOW: begin
                if (cancel || w_pe) begin
                    w_go_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_clr == CLR_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_clr_nxt = r_clr + CLR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Every abort path funnels into the same timed clear.
        if (w_go_clear) begin
            w_state_nxt = S_CLEAR;
            w_clr_nxt   = '0;
            w_idx_nxt   = '0;
        end

        // During a capture pulse y_sel names the operand being captured.
        w_y_sel_nxt = w_load_nxt ? r_idx : w_idx_nxt;
    end

    // State, counters and outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_press_q <= 1'b0;
            r_tmr     <= '0;
            r_clr     <= '0;
            r_y_sel   <= '0;
            r_load_en <= 1'b0;
            r_start   <= 1'b0;
            r_y_disp  <= 1'b0;
            r_reset_2 <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_press_q <= press;
            r_tmr     <= w_tmr_nxt;
            r_clr     <= w_clr_nxt;
            r_y_sel   <= w_y_sel_nxt;
            r_load_en <= w_load_nxt;
            r_start   <= (w_state_nxt == S_START);
            r_y_disp  <= (w_state_nxt == S_SHOW);
            r_reset_2 <= (w_state_nxt == S_CLEAR);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_err     <= w_err_nxt;
        end
    end

    assign y_sel   = r_y_sel;
    assign load_en = r_load_en;
    assign start   = r_start;
    assign y_disp  = r_y_disp;
    assign reset_2 = r_reset_2;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_module_fsm_seq.sv
// Bench for module_fsm_seq: two configurations share stimulus and are checked
// against a cycle-level behavioural model, fixed vectors and corner sequences.
module tb_module_fsm_seq;

    localparam int P_IDLE   = 0;
    localparam int P_ENTER  = 1;
    localparam int P_LAUNCH = 2;
    localparam int P_WAIT   = 3;
    localparam int P_SHOW   = 4;
    localparam int P_CLEAR  = 5;

    typedef struct packed {
        int phase;
        int idx;
        int waited;
        int clr_left;
        int y_sel;
        bit press_q;
        bit load_en;
        bit start;
        bit y_disp;
        bit reset_2;
        bit busy;
        bit err;
    } mdl_t;

    typedef struct {
        int rst, pr, cn, od;
        int ysel, ld, st, yd, r2, bz, er;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;
    logic cancel = 1'b0;
    logic op_done = 1'b0;

    logic [0:0] a_y_sel;
    logic       a_load_en, a_start, a_y_disp, a_reset_2, a_busy, a_err;
    logic [1:0] b_y_sel;
    logic       b_load_en, b_start, b_y_disp, b_reset_2, b_busy, b_err;

    int n_checks = 0;
    int n_err    = 0;
    mdl_t ma = '0;
    mdl_t mb = '0;
    vec_t tbl[17];

    always #5 clk = ~clk;

    module_fsm_seq #(.N_OPS(2), .TIMEOUT_CYC(8), .CLR_CYC(4)) u_a (
        .clk(clk), .reset(reset), .press(press), .cancel(cancel), .op_done(op_done),
        .y_sel(a_y_sel), .load_en(a_load_en), .start(a_start), .y_disp(a_y_disp),
        .reset_2(a_reset_2), .busy(a_busy), .err(a_err)
    );

    module_fsm_seq #(.N_OPS(4), .TIMEOUT_CYC(0), .CLR_CYC(3)) u_b (
        .clk(clk), .reset(reset), .press(press), .cancel(cancel), .op_done(op_done),
        .y_sel(b_y_sel), .load_en(b_load_en), .start(b_start), .y_disp(b_y_disp),
        .reset_2(b_reset_2), .busy(b_busy), .err(b_err)
    );

    // Behavioural model: one call per clock edge, phases and counters in plain ints.
    function automatic mdl_t step(input mdl_t m, input int n_ops, input int tmo,
                                  input int clr, input bit rst, input bit pr,
                                  input bit cn, input bit od);
        mdl_t n;
        bit pe;
        bit to_clear;
        n = m;
        to_clear = 1'b0;
        if (rst) begin
            n = '0;
        end else begin
            pe = pr && !m.press_q;
            n.press_q = pr;
            n.load_en = 1'b0;
            case (m.phase)
                P_IDLE: if (pe) begin n.phase = P_ENTER; n.idx = 0; n.err = 1'b0; end
                P_ENTER: begin
                    if (cn) to_clear = 1'b1;
                    else if (pe) begin
                        n.load_en = 1'b1;
                        if (m.idx + 1 < n_ops) n.idx = m.idx + 1;
                        else n.phase = P_LAUNCH;
                    end
                end
                P_LAUNCH: begin
                    if (cn) to_clear = 1'b1;
                    else begin n.phase = P_WAIT; n.waited = 0; end
                end
                P_WAIT: begin
                    if (cn) to_clear = 1'b1;
                    else if (od) n.phase = P_SHOW;
                    else begin
                        n.waited = m.waited + 1;
                        if (tmo != 0 && n.waited >= tmo) begin
                            n.err = 1'b1;
                            to_clear = 1'b1;
                        end
                    end
                end
                P_SHOW: if (cn || pe) to_clear = 1'b1;
                P_CLEAR: begin
                    n.clr_left = m.clr_left - 1;
                    if (n.clr_left == 0) n.phase = P_IDLE;
                end
                default: n.phase = P_IDLE;
            endcase
            if (to_clear) begin
                n.phase = P_CLEAR;
                n.clr_left = clr;
                n.idx = 0;
            end
            n.y_sel   = n.load_en ? m.idx : n.idx;
            n.start   = (n.phase == P_LAUNCH);
            n.y_disp  = (n.phase == P_SHOW);
            n.reset_2 = (n.phase == P_CLEAR);
            n.busy    = (n.phase != P_IDLE);
        end
        return n;
    endfunction

    function automatic logic [31:0] pack_mdl(input mdl_t m);
        return 32'(m.y_sel * 64 + int'(m.load_en) * 32 + int'(m.start) * 16 +
                   int'(m.y_disp) * 8 + int'(m.reset_2) * 4 + int'(m.busy) * 2 +
                   int'(m.err));
    endfunction

    function automatic logic [31:0] pack_vec(input vec_t v);
        return 32'(v.ysel * 64 + v.ld * 32 + v.st * 16 + v.yd * 8 + v.r2 * 4 +
                   v.bz * 2 + v.er);
    endfunction

    // Model advances on the same edges the DUTs see.
    always @(posedge clk) begin
        ma <= step(ma, 2, 8, 4, reset, press, cancel, op_done);
        mb <= step(mb, 4, 0, 3, reset, press, cancel, op_done);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model_a", 32'({a_y_sel, a_load_en, a_start, a_y_disp, a_reset_2, a_busy, a_err}),
            pack_mdl(ma));
        chk("model_b", 32'({b_y_sel, b_load_en, b_start, b_y_disp, b_reset_2, b_busy, b_err}),
            pack_mdl(mb));
    endtask

    task automatic pulse();
        press = 1'b1;
        tick();
        press = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;
        // {rst, press, cancel, op_done} -> {y_sel, load_en, start, y_disp, reset_2, busy, err}
        tbl[0]  = '{1,0,0,0, 0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0, 0,0,0,0,0,0,0};
        tbl[2]  = '{0,1,0,0, 0,0,0,0,0,1,0};
        tbl[3]  = '{0,0,0,0, 0,0,0,0,0,1,0};
        tbl[4]  = '{0,1,0,0, 0,1,0,0,0,1,0};
        tbl[5]  = '{0,0,0,0, 1,0,0,0,0,1,0};
        tbl[6]  = '{0,1,0,0, 1,1,1,0,0,1,0};
        tbl[7]  = '{0,0,0,0, 1,0,0,0,0,1,0};
        tbl[8]  = '{0,0,0,1, 1,0,0,1,0,1,0};
        tbl[9]  = '{0,0,0,0, 1,0,0,1,0,1,0};
        tbl[10] = '{0,1,0,0, 0,0,0,0,1,1,0};
        tbl[11] = '{0,1,0,0, 0,0,0,0,1,1,0};
        tbl[12] = '{0,1,0,0, 0,0,0,0,1,1,0};
        tbl[13] = '{0,1,0,0, 0,0,0,0,1,1,0};
        tbl[14] = '{0,1,0,0, 0,0,0,0,0,0,0};
        tbl[15] = '{0,1,0,1, 0,0,0,0,0,0,0};
        tbl[16] = '{0,0,1,0, 0,0,0,0,0,0,0};

        // Full operation on config A, held press across CLEAR, idle ignores.
        for (int k = 0; k < 17; k++) begin
            reset   = 1'(tbl[k].rst);
            press   = 1'(tbl[k].pr);
            cancel  = 1'(tbl[k].cn);
            op_done = 1'(tbl[k].od);
            tick();
            chk($sformatf("vec%0d", k),
                32'({a_y_sel, a_load_en, a_start, a_y_disp, a_reset_2, a_busy, a_err}),
                pack_vec(tbl[k]));
        end
        cancel = 1'b0;

        // Held press in ENTER gives exactly one capture.
        pulse();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            press = 1'b1;
            tick();
            cnt += int'(a_load_en);
        end
        chk("held_loads", 32'(cnt), 32'd1);
        chk("held_idx", 32'(a_y_sel), 32'd1);
        press = 1'b0;
        tick();

        // Cancel beats press in ENTER at idx 1.
        cancel = 1'b1;
        press  = 1'b1;
        tick();
        chk("cancel_no_load", 32'(a_load_en), 32'd0);
        chk("cancel_clear", 32'(a_reset_2), 32'd1);
        cancel = 1'b0;
        press  = 1'b0;
        repeat (3) tick();
        chk("cancel_clear_hold", 32'(a_reset_2), 32'd1);
        tick();
        chk("cancel_idle_busy", 32'(a_busy), 32'd0);
        chk("cancel_idle_ysel", 32'(a_y_sel), 32'd0);

        // Timeout: eight WAIT_DONE cycles without op_done.
        pulse();
        pulse();
        press = 1'b1;
        tick();
        chk("start_pulse", 32'(a_start), 32'd1);
        press = 1'b0;
        tick();
        chk("start_one_cycle", 32'(a_start), 32'd0);
        lat = 0;
        for (int t = 2; t <= 20; t++) begin
            tick();
            if (a_reset_2) begin
                lat = t;
                break;
            end
        end
        chk("timeout_latency", 32'(lat), 32'd9);
        chk("timeout_err", 32'(a_err), 32'd1);
        repeat (4) tick();
        chk("err_sticky_idle", 32'({a_busy, a_err}), 32'b01);
        press = 1'b1;
        tick();
        chk("err_cleared", 32'({a_busy, a_err}), 32'b10);
        press = 1'b0;
        tick();

        // op_done on the last permitted WAIT_DONE cycle wins over timeout.
        pulse();
        press = 1'b1;
        tick();
        press = 1'b0;
        tick();
        repeat (7) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("late_done_show", 32'({a_y_disp, a_reset_2, a_err}), 32'b100);
        press = 1'b1;
        tick();
        chk("show_to_clear", 32'(a_reset_2), 32'd1);
        press = 1'b0;
        repeat (4) tick();
        chk("clear_to_idle", 32'(a_busy), 32'd0);

        // Config B: four captures with y_sel 0..3, then reset in WAIT_DONE.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        pulse();
        for (int k = 0; k < 4; k++) begin
            press = 1'b1;
            tick();
            chk($sformatf("b_load%0d", k), 32'({b_load_en, b_y_sel}), 32'(4 + k));
            if (k == 3) chk("b_start", 32'(b_start), 32'd1);
            press = 1'b0;
            tick();
        end
        repeat (2) tick();
        chk("b_busy_wait", 32'({b_busy, b_y_disp}), 32'b10);
        reset = 1'b1;
        tick();
        chk("b_reset_outs",
            32'({b_y_sel, b_load_en, b_start, b_y_disp, b_reset_2, b_busy, b_err}), 32'd0);
        chk("a_reset_outs",
            32'({a_y_sel, a_load_en, a_start, a_y_disp, a_reset_2, a_busy, a_err}), 32'd0);
        reset = 1'b0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) press = ~press;
            cancel  = ($urandom_range(0, 19) == 0);
            op_done = ($urandom_range(0, 5) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
